// File: rtl/game_round_ctrl_if.sv
// Display/button bundle between game_round_ctrl and the DE2 board datapath.
// The controller uses the slave modport; the board side (or a bench) uses master.
interface game_round_ctrl_if;
    logic [3:0] KEY_N;
    logic [3:0] target;
    logic       led_hit;
    logic       led_miss;
    logic [7:0] score_bcd;
    logic [1:0] lives;
    logic [2:0] state;
    logic       game_over;

    modport master (
        output KEY_N,
        input  target, led_hit, led_miss, score_bcd, lives, state, game_over
    );

    modport slave (
        input  KEY_N,
        output target, led_hit, led_miss, score_bcd, lives, state, game_over
    );
endinterface

// File: rtl/game_round_ctrl.sv
// Round sequencer for the DE2 key-press reaction game: debounce, target pick, timing, scoring.
// Define GAME_SPEEDUP_EN to shrink the response window as the score grows.
module game_round_ctrl #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned DEB_MS   = 10,
    parameter int unsigned SHOW_MS  = 500,
    parameter int unsigned ROUND_MS = 1000,
    parameter int unsigned FB_MS    = 250,
    parameter int unsigned LIVES    = 3
) (
    input  logic               CLK,
    input  logic               RST,
    game_round_ctrl_if.slave   bus
);

    localparam int unsigned TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW     = $clog2(DEB_MS + 1);
    localparam int unsigned MAXLEN = (SHOW_MS > ROUND_MS) ?
                                     ((SHOW_MS > FB_MS) ? SHOW_MS : FB_MS) :
                                     ((ROUND_MS > FB_MS) ? ROUND_MS : FB_MS);
    localparam int unsigned TMW    = $clog2(MAXLEN + 1);

    localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0]  DEB_LAST   = DW'(DEB_MS - 1);
    localparam logic [TMW-1:0] SHOW_LEN   = TMW'(SHOW_MS);
    localparam logic [TMW-1:0] ROUND_LEN  = TMW'(ROUND_MS);
    localparam logic [TMW-1:0] FB_LEN     = TMW'(FB_MS);
    localparam logic [1:0]     LIVES_INIT = 2'(LIVES);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SHOW = 3'd1,
        WAIT = 3'd2,
        HIT  = 3'd3,
        MISS = 3'd4,
        OVER = 3'd5
    } state_t;

    state_t st, st_n;

    logic [3:0] sync1, sync2;
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bus.KEY_N;
            sync2 <= sync1;
        end
    end

    logic [TW-1:0] tick_cnt;
    logic          ms_tick;
    assign ms_tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge CLK) begin
        if (RST || ms_tick) tick_cnt <= '0;
        else                tick_cnt <= tick_cnt + 1'b1;
    end

    logic [3:0]    deb, press;
    logic [DW-1:0] deb_cnt [4];

    // press fires in the same edge the debounced level falls, so it trails deb by nothing
    always_ff @(posedge CLK) begin
        if (RST) begin
            deb   <= '1;
            press <= '0;
            for (int unsigned i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            press <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (ms_tick) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                        press[i]   <= ~sync2[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    logic press_any, press_multi;
    assign press_any   = |press;
    assign press_multi = (press & (press - 4'd1)) != 4'd0;

    logic [7:0] lfsr;
    always_ff @(posedge CLK) begin
        if (RST) lfsr <= 8'hA5;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    logic [7:0]     score, score_n, score_inc;
    logic [1:0]     lives_r, lives_n;
    logic [3:0]     target_r, target_n;
    logic           led_hit_r, led_miss_r, game_over_r;
    logic [TMW-1:0] timer, plen, wait_len;
    logic           t_end;

    assign t_end = ms_tick && (timer == TMW'(1));

    always_comb begin
        score_inc = score;
        if (score != 8'h99) begin
            if (score[3:0] == 4'd9) score_inc = {score[7:4] + 4'd1, 4'd0};
            else                    score_inc = {score[7:4], score[3:0] + 4'd1};
        end
    end

    always_comb begin
        st_n    = st;
        score_n = score;
        lives_n = lives_r;
        case (st)
            IDLE: if (press_any) begin
                st_n    = SHOW;
                score_n = '0;
                lives_n = LIVES_INIT;
            end
            SHOW: if (t_end) st_n = WAIT;
            WAIT: begin
                // a press on the timeout cycle is judged rather than treated as a timeout
                if (press_any) begin
                    if (!press_multi && press == target_r) begin
                        st_n    = HIT;
                        score_n = score_inc;
                    end else begin
                        st_n    = MISS;
                        lives_n = (lives_r != 2'd0) ? lives_r - 2'd1 : 2'd0;
                    end
                end else if (t_end) begin
                    st_n    = MISS;
                    lives_n = (lives_r != 2'd0) ? lives_r - 2'd1 : 2'd0;
                end
            end
            HIT:  if (t_end) st_n = SHOW;
            MISS: if (t_end) st_n = (lives_r == 2'd0) ? OVER : SHOW;
            OVER: if (press_any) st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    always_comb begin
        target_n = '0;
        case (st_n)
            SHOW: target_n = (st == SHOW) ? target_r : (4'b0001 << lfsr[1:0]);
            WAIT: target_n = target_r;
            default: target_n = '0;
        endcase
    end

`ifdef GAME_SPEEDUP_EN
    logic [TMW-1:0] window, window_n;
    logic [7:0]     spd_bin;
    logic [31:0]    spd_red;

    always_comb begin
        spd_bin = {4'd0, score_n[7:4]} * 8'd10 + {4'd0, score_n[3:0]};
        spd_red = 32'(spd_bin[7:2]) * (ROUND_MS / 8);
        if (spd_red > ROUND_MS - ROUND_MS / 4) window_n = TMW'(ROUND_MS / 4);
        else                                   window_n = TMW'(ROUND_MS - spd_red);
    end

    always_ff @(posedge CLK) begin
        if (RST)                            window <= ROUND_LEN;
        else if (st_n == SHOW && st != SHOW) window <= window_n;
    end

    assign wait_len = window;
`else
    assign wait_len = ROUND_LEN;
`endif

    always_comb begin
        plen = '0;
        case (st_n)
            SHOW:      plen = SHOW_LEN;
            WAIT:      plen = wait_len;
            HIT, MISS: plen = FB_LEN;
            default:   plen = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st          <= IDLE;
            score       <= '0;
            lives_r     <= LIVES_INIT;
            target_r    <= '0;
            led_hit_r   <= 1'b0;
            led_miss_r  <= 1'b0;
            game_over_r <= 1'b0;
            timer       <= '0;
        end else begin
            st          <= st_n;
            score       <= score_n;
            lives_r     <= lives_n;
            target_r    <= target_n;
            led_hit_r   <= (st_n == HIT);
            led_miss_r  <= (st_n == MISS);
            game_over_r <= (st_n == OVER);
            if (st_n != st)                      timer <= plen;
            else if (ms_tick && timer != '0)     timer <= timer - 1'b1;
        end
    end

    assign bus.target    = target_r;
    assign bus.led_hit   = led_hit_r;
    assign bus.led_miss  = led_miss_r;
    assign bus.score_bcd = score;
    assign bus.lives     = lives_r;
    assign bus.state     = st;
    assign bus.game_over = game_over_r;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with small timing parameters.
// Compile with GAME_SPEEDUP_EN defined to exercise the shrinking response window.
module tb_game_round_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_SHOW = 3'd1, S_WAIT = 3'd2,
                           S_HIT  = 3'd3, S_MISS = 3'd4, S_OVER = 3'd5;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    game_round_ctrl_if bus ();

    game_round_ctrl #(
        .TICK_DIV (2),
        .DEB_MS   (2),
        .SHOW_MS  (4),
        .ROUND_MS (8),
        .FB_MS    (2),
        .LIVES    (3)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int n);
        int m;
        m = (n > 99) ? 99 : n;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n;
        n = 0;
        while (bus.state !== s && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(tag, 32'(bus.state), 32'(s));
    endtask

    // Counts clocks spent in WAIT starting at a negedge already in WAIT.
    task automatic measure_wait(input int start, output int cyc);
        cyc = start;
        while (bus.state === S_WAIT && cyc < 100) begin
            cyc++;
            @(negedge CLK);
        end
    endtask

    task automatic hit_round(input string tag);
        int lane;
        int n;
        wait_state(S_WAIT, 200, {tag, "_wait"});
        lane = 0;
        for (int i = 0; i < 4; i++) if (bus.target[i]) lane = i;
        bus.KEY_N[lane] = 1'b0;
        n = 0;
        while (bus.state === S_WAIT && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_hit"}, 32'(bus.state), 32'(S_HIT));
        bus.KEY_N = '1;
    endtask

    int cyc;
    int sc;
    logic [3:0] tgt;

    initial begin
        bus.KEY_N = '1;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_state",  32'(bus.state),     32'(S_IDLE));
        check("rst_score",  32'(bus.score_bcd), 32'h00);
        check("rst_lives",  32'(bus.lives),     32'd3);
        check("rst_target", 32'(bus.target),    32'h0);
        check("rst_leds",   32'({bus.led_hit, bus.led_miss, bus.game_over}), 32'h0);
        RST = 1'b0;

        bus.KEY_N[0] = 1'b0;
        repeat (10) @(negedge CLK);
        check("start_show", 32'(bus.state), 32'(S_SHOW));
        tgt = bus.target;
        check("start_onehot", 32'((tgt != 4'd0) && ((tgt & (tgt - 4'd1)) == 4'd0)), 32'd1);
        bus.KEY_N = '1;

        wait_state(S_WAIT, 50, "wait1");
        check("wait_target_held", 32'(bus.target), 32'(tgt));
        hit_round("hit1");
        check("hit1_led",    32'(bus.led_hit),   32'd1);
        check("hit1_target", 32'(bus.target),    32'h0);
        check("hit1_score",  32'(bus.score_bcd), 32'h01);
        wait_state(S_SHOW, 30, "hit1_show");

        wait_state(S_WAIT, 50, "glitch_wait");
        bus.KEY_N[2] = 1'b0;
        @(negedge CLK);
        bus.KEY_N[2] = 1'b1;
        repeat (4) @(negedge CLK);
        check("glitch_ignored", 32'(bus.state), 32'(S_WAIT));
        measure_wait(5, cyc);
        check("timeout_ticks", 32'((cyc + 1) / 2), 32'd8);
        check("miss1_state", 32'(bus.state),    32'(S_MISS));
        check("miss1_led",   32'(bus.led_miss), 32'd1);
        check("miss1_lives", 32'(bus.lives),    32'd2);
        check("miss1_tgt",   32'(bus.target),   32'h0);

        for (int k = 1; k <= 2; k++) begin
            wait_state(S_WAIT, 50, "to_wait");
            measure_wait(0, cyc);
            check("to_miss",  32'(bus.state), 32'(S_MISS));
            check("to_lives", 32'(bus.lives), 32'(2 - k));
        end
        wait_state(S_OVER, 30, "over_state");
        check("over_flag",  32'(bus.game_over), 32'd1);
        check("over_score", 32'(bus.score_bcd), 32'h01);

        bus.KEY_N[3] = 1'b0;
        wait_state(S_IDLE, 30, "over_to_idle");
        bus.KEY_N = '1;
        repeat (20) @(negedge CLK);
        check("idle_no_start", 32'(bus.state),     32'(S_IDLE));
        check("idle_score",    32'(bus.score_bcd), 32'h01);
        check("idle_flag",     32'(bus.game_over), 32'd0);

        bus.KEY_N[1] = 1'b0;
        repeat (10) @(negedge CLK);
        check("restart_show",  32'(bus.state),     32'(S_SHOW));
        check("restart_score", 32'(bus.score_bcd), 32'h00);
        check("restart_lives", 32'(bus.lives),     32'd3);
        bus.KEY_N = '1;

        sc = 0;
        for (int k = 0; k < 8; k++) begin
            hit_round("run");
            sc++;
            check("run_score", 32'(bus.score_bcd), 32'(bcd(sc)));
        end

        wait_state(S_WAIT, 50, "spd_wait");
        measure_wait(0, cyc);
`ifdef GAME_SPEEDUP_EN
        check("spd_ticks", 32'((cyc + 1) / 2), 32'd6);
`else
        check("spd_ticks", 32'((cyc + 1) / 2), 32'd8);
`endif
        check("spd_lives", 32'(bus.lives), 32'd2);

`ifndef GAME_SPEEDUP_EN
        while (sc < 100) begin
            hit_round("sat");
            sc++;
            check("sat_score", 32'(bus.score_bcd), 32'(bcd(sc)));
        end
`endif

        wait_state(S_WAIT, 50, "multi_wait");
        bus.KEY_N[1:0] = 2'b00;
        cyc = 0;
        while (bus.state === S_WAIT && cyc < 40) begin
            @(negedge CLK);
            cyc++;
        end
        check("multi_miss",  32'(bus.state), 32'(S_MISS));
        check("multi_lives", 32'(bus.lives), 32'd1);
        bus.KEY_N = '1;

        wait_state(S_WAIT, 50, "abort_wait");
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("abort_state",  32'(bus.state),     32'(S_IDLE));
        check("abort_score",  32'(bus.score_bcd), 32'h00);
        check("abort_lives",  32'(bus.lives),     32'd3);
        check("abort_target", 32'(bus.target),    32'h0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Round sequencer for the DE2 key-press reaction game.
- Debounces the four raw active-low push-buttons and picks a pseudo-random target lane each round.
- Times the show and response windows, then judges each press as hit or miss.
- Keeps the BCD score and lives count, and drives target/feedback/score signals to the game display datapath (LEDR/LEDG/HEX).

Parameters:
- TICK_DIV, 50000: clocks per 1 ms tick (50 MHz board clock).
- DEB_MS, 10: ticks a key must be stable before a level change is accepted.
- SHOW_MS, 500: ticks the target is shown before responses are accepted.
- ROUND_MS, 1000: ticks of the response window.
- FB_MS, 250: ticks of the hit/miss feedback phase.
- LIVES, 3: starting lives (1..3).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset (board wires SW[17])
- KEY_N  in  4  raw push-buttons, active-low, asynchronous to CLK
- target  out  4  one-hot target lane; 0 when no target
- led_hit  out  1  high during HIT feedback
- led_miss  out  1  high during MISS feedback
- score_bcd  out  8  two BCD digits {tens, ones}
- lives  out  2  remaining lives
- state  out  3  IDLE=0 SHOW=1 WAIT=2 HIT=3 MISS=4 OVER=5
- game_over  out  1  high in OVER

Behaviour:
- Reset: all logic is sampled on CLK rising edge; RST wins over everything.
  - On RST=1: state=IDLE, target=0, led_hit=led_miss=0, score_bcd=0, lives=LIVES, game_over=0.
  - Also cleared: tick divider, phase timer, debouncers (held released), LFSR=8'hA5.
  - RST asserted mid-round aborts the round immediately; no score or lives update.
- Synchronizer: KEY_N passes through 2 flops.
- Tick: ms_tick is a 1-clock pulse every TICK_DIV clocks, free-running from reset.
- Debounce, per key:
  - Counter advances on ms_tick while the synced level differs from the debounced level; it clears when they match.
  - At DEB_MS the debounced level flips.
  - press[i] is a 1-clock pulse on the debounced high-to-low transition.
- Judging: press_any = |press; press_multi = more than one press bit set in the same cycle.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4, shifts every clock.
  - lane = lfsr[1:0], sampled on the cycle SHOW is entered; target = 1<<lane.
- Phase timer: loaded with the phase length on state entry; decremented on ms_tick; phase ends on the tick that reaches 0.
- FSM:
  - IDLE: press_any -> SHOW, with score cleared and lives reloaded to LIVES.
  - SHOW: target driven. Presses are ignored. Timer end -> WAIT.
  - WAIT: target driven.
    - press equal to target (single key) -> HIT.
    - Wrong key or press_multi -> MISS.
    - Timer end with no press -> MISS.
    - A press on the timer-end cycle is judged; the press wins over timeout.
  - HIT: target=0, led_hit=1, score +1 BCD on entry, saturating at 8'h99. Timer end -> SHOW.
  - MISS: target=0, led_miss=1, lives -1 on entry.
    - Timer end with lives=0 -> OVER; otherwise -> SHOW.
  - OVER: game_over=1, score held. press_any -> IDLE; that press does not also start a game.
- BCD increment: ones 9 -> 0 with carry into tens. 99 stays 99.
- All outputs are registered; target and LEDs change 1 clock after the state decision.

Optional Feature:
- Macro: GAME_SPEEDUP_EN.
- Defined:
  - Response window = ROUND_MS - (ROUND_MS/8)*floor(score/4), with score taken as binary equivalent.
  - The window is floored at ROUND_MS/4.
  - Recomputed on each SHOW entry.
- Undefined: window is constant ROUND_MS and the speed-up logic is absent.

Test Plan (TICK_DIV=2, DEB_MS=2, SHOW_MS=4, ROUND_MS=8, FB_MS=2, LIVES=3):
- Reset check: assert RST 3 clocks -> state=0, score_bcd=00, lives=3, target=0.
- Start and hit: hold KEY_N[0] low 10 clocks in IDLE -> SHOW. Then press the key matching target during WAIT -> state=3, led_hit=1, score_bcd=01, then SHOW again.
- Glitch rejection: a 1-clock low glitch on KEY_N[2] during WAIT -> no press, no state change. A timeout then gives MISS with lives=2.
- Game over: three consecutive timeouts -> lives 3->2->1->0, then OVER with game_over=1. A key press -> IDLE with score held until the next start.
- Saturation and multi-press: preload score=98 with two hits -> score_bcd=99 then stays 99. Two keys debounced in the same cycle during WAIT -> MISS.
- Speed-up and abort: with GAME_SPEEDUP_EN and score=8, WAIT lasts 6 ticks. RST mid-WAIT -> IDLE next clock with score=00.
